// File: rtl/hs4p_sync_responder.sv
// Clocked responder for a 4-phase bundled-data handshake: synchronizes req_i, captures data_i
// into an FWFT FIFO, returns ack_o and presents the words on a valid/ready port.
`timescale 1ns/1ps

module hs4p_sync_responder #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     ack_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  // Single-bit encoding keeps ack_o a direct flop output, glitch-free toward the async stage.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_i};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_full  = (r_count == L_DEPTH);
  assign w_pop   = out_valid_o & out_ready_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_s && !w_full) w_state_nxt = S_ACK;
      S_ACK:   if (!w_req_s)           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fullness is judged before this edge's pop, so a same-edge pop never frees room for a push.
  always_comb begin
    w_push = 1'b0;
    ack_o  = 1'b0;
    case (r_state)
      S_IDLE:  w_push = w_req_s && !w_full;
      S_ACK:   ack_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push && !wb_rst_i) r_mem[r_wptr] <= data_i;
  end

  assign out_valid_o = (r_count != '0);
  assign out_data_o  = r_mem[r_rptr];
  assign count_o     = r_count;

endmodule

// File: tb/tb_hs4p_sync_responder.sv
// Bench for hs4p_sync_responder: an async-sender emulation and consumer drive the DUT while a
// queue-based reference model predicts ack/valid/count/head every cycle.
`timescale 1ns/1ps

module tb_hs4p_sync_responder;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int SS     = 2;
  localparam int BUDGET = 200;

  logic             clk;
  logic             wb_rst_i;
  logic             req_i;
  logic [WIDTH-1:0] data_i;
  logic             ack_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready;
  logic [2:0]       count_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  logic rdy_manual = 0;
  logic rdy_auto = 0;
  bit   busy = 0;

  assign out_ready = (rdy_mode == 0) ? rdy_manual : rdy_auto;

  hs4p_sync_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready),
    .count_o    (count_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the request is seen SS edges late; one word per request, queue of DEPTH.
  logic [WIDTH-1:0] q[$];
  bit               hist[$];
  bit               m_ack = 0;
  bit               started = 0;

  always @(posedge clk) begin
    bit rs, cap, pop;
    int sz;
    if (wb_rst_i) begin
      q.delete();
      hist.delete();
      m_ack   = 0;
      started = 1;
    end else begin
      rs = (hist.size() == SS) ? hist[0] : 1'b0;
      hist.push_back(req_i);
      if (hist.size() > SS) void'(hist.pop_front());
      sz  = q.size();
      pop = (sz > 0) && out_ready;
      cap = 0;
      if (!m_ack) begin
        if (rs && sz < DEPTH) begin
          cap   = 1;
          m_ack = 1;
        end
      end else if (!rs) begin
        m_ack = 0;
      end
      if (pop) void'(q.pop_front());
      if (cap) q.push_back(data_i);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check_eq("ack", {31'b0, ack_o}, {31'b0, m_ack});
      check_eq("valid", {31'b0, out_valid_o}, (q.size() != 0) ? 32'd1 : 32'd0);
      check_eq("count", {29'b0, count_o}, q.size());
      if (q.size() != 0) check_eq("head", {28'b0, out_data_o}, {28'b0, q[0]});
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       rdy_auto = ~rdy_auto;
      2:       rdy_auto = ($urandom_range(0, 2) == 0);
      default: rdy_auto = 1'b0;
    endcase
  end

  task automatic wait_ack(input logic v);
    int k = 0;
    while (ack_o !== v && k < BUDGET) begin
      @(posedge clk); #1;
      k++;
    end
    if (ack_o !== v) check_eq("ack_timeout", {31'b0, ack_o}, {31'b0, v});
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int hold);
    @(posedge clk); #1;
    data_i = d;
    req_i  = 1'b1;
    wait_ack(1'b1);
    repeat (hold) @(posedge clk);
    #1;
    req_i = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < BUDGET) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) check_eq("send_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1;
    req_i    = 1'b0;
    data_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'b0, ack_o}, 32'd0);
    check_eq("rst_count", {29'b0, count_o}, 32'd0);
    check_eq("rst_valid", {31'b0, out_valid_o}, 32'd0);
    wb_rst_i = 1'b0;

    // Single transfer, consumer stalled
    send(4'hA, 1);
    check_eq("single_count", {29'b0, count_o}, 32'd1);
    check_eq("single_data", {28'b0, out_data_o}, 32'hA);
    rdy_manual = 1'b1;
    repeat (3) @(posedge clk);

    // Back-to-back stream with request held high a few extra cycles
    for (int i = 1; i <= 4; i++) send(WIDTH'(i), $urandom_range(0, 5));
    repeat (3) @(posedge clk);
    #1;
    check_eq("stream_empty", {29'b0, count_o}, 32'd0);

    // Full backpressure, then a single pop frees room for the blocked word
    rdy_manual = 1'b0;
    for (int i = 5; i <= 8; i++) send(WIDTH'(i), 0);
    fork
      begin
        busy = 1;
        send(4'h9, 1);
        busy = 0;
      end
    join_none
    repeat (8) @(posedge clk);
    #1;
    check_eq("bp_count", {29'b0, count_o}, 32'd4);
    check_eq("bp_ack", {31'b0, ack_o}, 32'd0);
    check_eq("bp_head", {28'b0, out_data_o}, 32'd5);
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    rdy_manual = 1'b0;
    check_eq("pop_only_count", {29'b0, count_o}, 32'd3);
    check_eq("pop_only_ack", {31'b0, ack_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("push_next_count", {29'b0, count_o}, 32'd4);
    check_eq("push_next_ack", {31'b0, ack_o}, 32'd1);
    wait_idle();
    rdy_manual = 1'b1;
    repeat (8) @(posedge clk);

    // Pointer wrap with consumer toggling every cycle
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send(WIDTH'(i), $urandom_range(0, 2));
    repeat (12) @(posedge clk);
    #1;
    check_eq("wrap_empty", {29'b0, count_o}, 32'd0);
    rdy_mode   = 0;
    rdy_manual = 1'b0;

    // Reset during an acknowledged handshake; request still high afterwards
    fork
      begin
        busy = 1;
        send(4'hC, 20);
        busy = 0;
      end
    join_none
    wait_ack(1'b1);
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    check_eq("mid_rst_ack", {31'b0, ack_o}, 32'd0);
    check_eq("mid_rst_count", {29'b0, count_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("re_ack_early", {31'b0, ack_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("re_ack", {31'b0, ack_o}, 32'd1);
    check_eq("re_count", {29'b0, count_o}, 32'd1);
    wait_idle();
    rdy_manual = 1'b1;
    repeat (4) @(posedge clk);

    // Randomized traffic with a mostly-stalled consumer
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(WIDTH'($urandom), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode   = 0;
    rdy_manual = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("final_count", {29'b0, count_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
